llsc_link_unit: RTL and testbench

Per-core LL/SC reservation tracker and store-conditional result producer. It sits beside the dcache request path in the MEM stage. It records the address of a load-linked, watches local stores and coherence snoop invalidations that break the link, and gates the SC memory write. It returns the SC success value (1/0) that the pipeline writes to rt and forwards downstream.

---
 rtl/llsc_link_unit_pkg.sv | 14 +
 rtl/llsc_link_unit_match.sv | 13 +
 rtl/llsc_link_unit.sv | 155 +++++++++++++++
 tb/tb_llsc_link_unit.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/llsc_link_unit_pkg.sv
// Shared types and constants for the LL/SC reservation tracker.
package llsc_link_unit_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LINKED   = 2'd1,
        SC_WRITE = 2'd2,
        SC_DONE  = 2'd3
    } llsc_state_t;

    localparam logic [31:0] SC_SUCCESS = 32'h1;
    localparam logic [31:0] SC_FAIL    = 32'h0;

endpackage

// File: rtl/llsc_link_unit_match.sv
// Block-address comparator: equality of the address bits above the block offset.
// Purely combinational; callers pass only the block field so offset bits never reach here.
module link_match #(
    parameter int BLK_W = 29
) (
    input  logic [BLK_W-1:0] a_blk,
    input  logic [BLK_W-1:0] b_blk,
    output logic             hit
);

    assign hit = (a_blk == b_blk);

endmodule

// File: rtl/llsc_link_unit.sv
// Per-core LL/SC reservation tracker: holds the LL block, breaks it on matching stores,
// snoops or idle timeout, gates the SC write and reports a 1/0 result pulse.
module llsc_link_unit
    import llsc_link_unit_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int BLK_LSB      = 3,
    parameter int LINK_TIMEOUT = 0
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ll_req,
    input  logic              sc_req,
    input  logic              sw_req,
    input  logic [ADDR_W-1:0] addr,
    input  logic              dhit,
    input  logic              snoop_inv,
    input  logic [ADDR_W-1:0] snoop_addr,
    output logic              link_valid,
    output logic [ADDR_W-1:0] link_addr,
    output logic              sc_wen,
    output logic              sc_done,
    output logic [31:0]       sc_result
);

    localparam int                BLK_W    = ADDR_W - BLK_LSB;
    localparam logic [ADDR_W-1:0] BLK_MASK = {{BLK_W{1'b1}}, {BLK_LSB{1'b0}}};

    llsc_state_t       state_q, state_d;
    logic [ADDR_W-1:0] link_addr_q, link_addr_d;
    logic [31:0]       sc_result_q, sc_result_d;

    logic addr_hit;
    logic snoop_hit;
    logic snoop_brk;
    logic ll_collide;
    logic tmo_hit;
    logic unused_snoop_lsb;

    // Offset bits of the snooped address never influence a block match.
    assign unused_snoop_lsb = ^snoop_addr[BLK_LSB-1:0];

    link_match #(.BLK_W(BLK_W)) u_addr_match (
        .a_blk (addr[ADDR_W-1:BLK_LSB]),
        .b_blk (link_addr_q[ADDR_W-1:BLK_LSB]),
        .hit   (addr_hit)
    );

    link_match #(.BLK_W(BLK_W)) u_snoop_match (
        .a_blk (snoop_addr[ADDR_W-1:BLK_LSB]),
        .b_blk (link_addr_q[ADDR_W-1:BLK_LSB]),
        .hit   (snoop_hit)
    );

    assign snoop_brk  = snoop_inv && snoop_hit;
    // An LL racing an invalidation of its own block must not establish a link.
    assign ll_collide = snoop_inv && (addr[ADDR_W-1:BLK_LSB] == snoop_addr[ADDR_W-1:BLK_LSB]);

    generate
        if (LINK_TIMEOUT > 0) begin : g_tmo
            localparam int             CW       = $clog2(LINK_TIMEOUT + 1);
            localparam logic [CW-1:0]  TMO_LAST = CW'(LINK_TIMEOUT - 1);

            logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
            logic          idle_linked;

            assign idle_linked = (state_q == LINKED) && !(ll_req || sc_req || sw_req);
            assign tmo_hit     = idle_linked && (tmo_cnt_q == TMO_LAST);

            // Held at zero outside LINKED so every entry starts a fresh count.
            always_comb begin
                tmo_cnt_d = tmo_cnt_q;
                if ((state_q != LINKED) || ll_req) begin
                    tmo_cnt_d = '0;
                end else if (idle_linked && (tmo_cnt_q != TMO_LAST)) begin
                    tmo_cnt_d = tmo_cnt_q + CW'(1);
                end
            end

            always_ff @(posedge CLK or negedge nRST) begin
                if (!nRST) begin
                    tmo_cnt_q <= '0;
                end else begin
                    tmo_cnt_q <= tmo_cnt_d;
                end
            end
        end else begin : g_no_tmo
            assign tmo_hit = 1'b0;
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        link_addr_d = link_addr_q;
        sc_result_d = sc_result_q;
        case (state_q)
            IDLE, LINKED: begin
                if (sc_req) begin
                    if ((state_q == LINKED) && addr_hit && !snoop_brk) begin
                        state_d = SC_WRITE;
                    end else begin
                        state_d     = SC_DONE;
                        sc_result_d = SC_FAIL;
                    end
                end else if (ll_req && dhit) begin
                    if (ll_collide) begin
                        state_d = IDLE;
                    end else begin
                        state_d     = LINKED;
                        link_addr_d = addr & BLK_MASK;
                    end
                end else if (state_q == LINKED) begin
                    if (snoop_brk || (sw_req && dhit && addr_hit) || tmo_hit) begin
                        state_d = IDLE;
                    end
                end
            end
            SC_WRITE: begin
                // A completed write outranks a same-cycle snoop: the bus already ordered it.
                if (dhit) begin
                    state_d     = SC_DONE;
                    sc_result_d = SC_SUCCESS;
                end else if (snoop_brk) begin
                    state_d     = SC_DONE;
                    sc_result_d = SC_FAIL;
                end
            end
            SC_DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            link_addr_q <= '0;
            sc_result_q <= SC_FAIL;
        end else begin
            state_q     <= state_d;
            link_addr_q <= link_addr_d;
            sc_result_q <= sc_result_d;
        end
    end

    assign link_valid = (state_q == LINKED) || (state_q == SC_WRITE);
    assign link_addr  = link_addr_q;
    assign sc_wen     = (state_q == SC_WRITE);
    assign sc_done    = (state_q == SC_DONE);
    assign sc_result  = sc_result_q;

endmodule

// File: tb/tb_llsc_link_unit.sv
// Bench for llsc_link_unit: directed scenarios plus a randomized run against a
// transaction-level reservation model.
module tb_llsc_link_unit;

    localparam int AW  = 32;
    localparam int TMO = 4;

    logic          CLK = 1'b0;
    logic          nRST = 1'b0;
    logic          ll_req, sc_req, sw_req, dhit, snoop_inv;
    logic [AW-1:0] addr, snoop_addr;
    logic          link_valid, sc_wen, sc_done;
    logic [AW-1:0] link_addr;
    logic [31:0]   sc_result;

    int vecs = 0;
    int errs = 0;

    // Reservation model state
    bit          m_linked, m_writing, m_done;
    logic [28:0] m_blk;
    logic [31:0] m_result;
    int          m_idle;

    llsc_link_unit #(.ADDR_W(AW), .BLK_LSB(3), .LINK_TIMEOUT(TMO)) dut (
        .CLK(CLK), .nRST(nRST), .ll_req(ll_req), .sc_req(sc_req), .sw_req(sw_req),
        .addr(addr), .dhit(dhit), .snoop_inv(snoop_inv), .snoop_addr(snoop_addr),
        .link_valid(link_valid), .link_addr(link_addr), .sc_wen(sc_wen),
        .sc_done(sc_done), .sc_result(sc_result)
    );

    always #5 CLK = ~CLK;

    task automatic idle_inputs();
        ll_req = 0; sc_req = 0; sw_req = 0; dhit = 0; snoop_inv = 0;
        addr = '0; snoop_addr = '0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_ll(input logic [AW-1:0] a);
        idle_inputs(); ll_req = 1; dhit = 1; addr = a;
        tick();
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        nRST = 0;
        repeat (2) @(posedge CLK);
        #1;
        vecs++; if (link_valid !== 1'b0) begin errs++; $display("FAIL reset_link_valid: got %0h want 0", link_valid); end
        vecs++; if (link_addr !== '0) begin errs++; $display("FAIL reset_link_addr: got %0h want 0", link_addr); end
        vecs++; if (sc_wen !== 1'b0) begin errs++; $display("FAIL reset_sc_wen: got %0h want 0", sc_wen); end
        vecs++; if (sc_done !== 1'b0) begin errs++; $display("FAIL reset_sc_done: got %0h want 0", sc_done); end
        vecs++; if (sc_result !== 32'h0) begin errs++; $display("FAIL reset_sc_result: got %0h want 0", sc_result); end
        nRST = 1;
        tick();
    endtask

    task automatic test_sc_success();
        int wen_cycles = 0;
        do_ll(32'h100);
        vecs++; if (link_valid !== 1'b1) begin errs++; $display("FAIL ll_link_valid: got %0h want 1", link_valid); end
        vecs++; if (link_addr !== 32'h100) begin errs++; $display("FAIL ll_link_addr: got %0h want 100", link_addr); end
        sc_req = 1; addr = 32'h104;
        tick();
        for (int i = 0; i < 3; i++) begin
            dhit = (i == 2);
            if (sc_wen === 1'b1) wen_cycles++;
            vecs++; if (sc_done !== 1'b0) begin errs++; $display("FAIL sc_early_done: got %0h want 0 (cycle %0d)", sc_done, i); end
            tick();
        end
        vecs++; if (wen_cycles != 3) begin errs++; $display("FAIL sc_wen_cycles: got %0d want 3", wen_cycles); end
        vecs++; if (sc_done !== 1'b1) begin errs++; $display("FAIL sc_ok_done: got %0h want 1", sc_done); end
        vecs++; if (sc_result !== 32'h1) begin errs++; $display("FAIL sc_ok_result: got %0h want 1", sc_result); end
        vecs++; if (link_valid !== 1'b0) begin errs++; $display("FAIL sc_ok_link_valid: got %0h want 0", link_valid); end
        vecs++; if (sc_wen !== 1'b0) begin errs++; $display("FAIL sc_ok_wen_off: got %0h want 0", sc_wen); end
        idle_inputs();
        tick();
        vecs++; if (sc_done !== 1'b0) begin errs++; $display("FAIL sc_ok_pulse_width: got %0h want 0", sc_done); end
        vecs++; if (sc_result !== 32'h1) begin errs++; $display("FAIL sc_ok_result_hold: got %0h want 1", sc_result); end
    endtask

    task automatic test_snoop_break();
        do_ll(32'h100);
        snoop_inv = 1; snoop_addr = 32'h100;
        tick();
        idle_inputs();
        vecs++; if (link_valid !== 1'b0) begin errs++; $display("FAIL snoop_break_link: got %0h want 0", link_valid); end
        sc_req = 1; addr = 32'h100;
        tick();
        vecs++; if (sc_wen !== 1'b0) begin errs++; $display("FAIL snoop_break_wen: got %0h want 0", sc_wen); end
        vecs++; if (sc_done !== 1'b1) begin errs++; $display("FAIL snoop_break_done: got %0h want 1", sc_done); end
        vecs++; if (sc_result !== 32'h0) begin errs++; $display("FAIL snoop_break_result: got %0h want 0", sc_result); end
        idle_inputs();
        tick();
    endtask

    task automatic test_nonmatch();
        do_ll(32'h100);
        snoop_inv = 1; snoop_addr = 32'h200;
        tick();
        idle_inputs();
        vecs++; if (link_valid !== 1'b1) begin errs++; $display("FAIL far_snoop_link: got %0h want 1", link_valid); end
        sw_req = 1; dhit = 1; addr = 32'h108;
        tick();
        idle_inputs();
        vecs++; if (link_valid !== 1'b1) begin errs++; $display("FAIL far_sw_link: got %0h want 1", link_valid); end
        sc_req = 1; addr = 32'h100;
        tick();
        vecs++; if (sc_wen !== 1'b1) begin errs++; $display("FAIL far_sc_wen: got %0h want 1", sc_wen); end
        dhit = 1;
        tick();
        vecs++; if (sc_done !== 1'b1) begin errs++; $display("FAIL far_sc_done: got %0h want 1", sc_done); end
        vecs++; if (sc_result !== 32'h1) begin errs++; $display("FAIL far_sc_result: got %0h want 1", sc_result); end
        idle_inputs();
        tick();
    endtask

    task automatic test_sc_race();
        // Snoop alone during the write aborts it.
        do_ll(32'h100);
        sc_req = 1; addr = 32'h100;
        tick();
        snoop_inv = 1; snoop_addr = 32'h100;
        tick();
        vecs++; if (sc_wen !== 1'b0) begin errs++; $display("FAIL abort_wen: got %0h want 0", sc_wen); end
        vecs++; if (sc_done !== 1'b1) begin errs++; $display("FAIL abort_done: got %0h want 1", sc_done); end
        vecs++; if (sc_result !== 32'h0) begin errs++; $display("FAIL abort_result: got %0h want 0", sc_result); end
        idle_inputs();
        tick();
        // Snoop together with dhit: the write stands.
        do_ll(32'h100);
        sc_req = 1; addr = 32'h100;
        tick();
        snoop_inv = 1; snoop_addr = 32'h100; dhit = 1;
        tick();
        vecs++; if (sc_done !== 1'b1) begin errs++; $display("FAIL race_done: got %0h want 1", sc_done); end
        vecs++; if (sc_result !== 32'h1) begin errs++; $display("FAIL race_result: got %0h want 1", sc_result); end
        idle_inputs();
        tick();
    endtask

    task automatic test_timeout();
        do_ll(32'h40);
        vecs++; if (link_valid !== 1'b1) begin errs++; $display("FAIL tmo_entry: got %0h want 1", link_valid); end
        for (int k = 1; k <= TMO; k++) begin
            tick();
            vecs++;
            if (link_valid !== (k < TMO)) begin
                errs++; $display("FAIL tmo_link_cycle%0d: got %0h want %0h", k, link_valid, (k < TMO));
            end
        end
        sc_req = 1; addr = 32'h40;
        tick();
        vecs++; if (sc_done !== 1'b1) begin errs++; $display("FAIL tmo_sc_done: got %0h want 1", sc_done); end
        vecs++; if (sc_result !== 32'h0) begin errs++; $display("FAIL tmo_sc_result: got %0h want 0", sc_result); end
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid_sc();
        do_ll(32'h100);
        sc_req = 1; addr = 32'h100;
        tick();
        vecs++; if (sc_wen !== 1'b1) begin errs++; $display("FAIL mid_pre_wen: got %0h want 1", sc_wen); end
        #2 nRST = 0;
        #1;
        vecs++; if ({link_valid, sc_wen, sc_done} !== 3'b000) begin errs++; $display("FAIL mid_rst_flags: got %0b want 000", {link_valid, sc_wen, sc_done}); end
        vecs++; if (sc_result !== 32'h0) begin errs++; $display("FAIL mid_rst_result: got %0h want 0", sc_result); end
        vecs++; if (link_addr !== '0) begin errs++; $display("FAIL mid_rst_addr: got %0h want 0", link_addr); end
        idle_inputs();
        tick();
        nRST = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vecs++; if (sc_done !== 1'b0) begin errs++; $display("FAIL mid_rst_ghost_done: got %0h want 0 (cycle %0d)", sc_done, i); end
        end
        do_ll(32'h100);
        sc_req = 1; addr = 32'h100;
        tick();
        dhit = 1;
        tick();
        vecs++; if (sc_done !== 1'b1) begin errs++; $display("FAIL mid_fresh_done: got %0h want 1", sc_done); end
        vecs++; if (sc_result !== 32'h1) begin errs++; $display("FAIL mid_fresh_result: got %0h want 1", sc_result); end
        idle_inputs();
        tick();
    endtask

    function automatic logic [AW-1:0] rand_addr();
        logic [AW-1:0] pool [4];
        pool[0] = 32'h100; pool[1] = 32'h108; pool[2] = 32'h200; pool[3] = 32'h40;
        return pool[$urandom_range(3)] | AW'($urandom_range(7));
    endfunction

    // Advances the reservation model by one cycle from the currently driven inputs.
    task automatic model_step();
        bit snoop_kills = snoop_inv && (snoop_addr[AW-1:3] == m_blk);
        bit same_blk    = (addr[AW-1:3] == m_blk);
        if (m_done) begin
            m_done = 0;
        end else if (m_writing) begin
            if (dhit || snoop_kills) begin
                m_writing = 0; m_done = 1; m_linked = 0;
                m_result  = dhit ? 32'h1 : 32'h0;
            end
        end else if (sc_req) begin
            if (m_linked && same_blk && !snoop_kills) begin
                m_writing = 1;
            end else begin
                m_done = 1; m_result = 32'h0; m_linked = 0;
            end
        end else if (ll_req && dhit) begin
            if (snoop_inv && (snoop_addr[AW-1:3] == addr[AW-1:3])) begin
                m_linked = 0;
            end else begin
                m_linked = 1; m_blk = addr[AW-1:3]; m_idle = 0;
            end
        end else if (m_linked) begin
            if (snoop_kills || (sw_req && dhit && same_blk)) m_linked = 0;
            else if (ll_req) m_idle = 0;
            else if (!sw_req) begin
                if (m_idle == TMO - 1) m_linked = 0;
                else m_idle++;
            end
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] sc_addr = '0;
        int            pick;
        idle_inputs();
        nRST = 0; #1; nRST = 1;
        m_linked = 0; m_writing = 0; m_done = 0; m_blk = '0; m_result = 32'h0; m_idle = 0;
        for (int c = 0; c < 600; c++) begin
            idle_inputs();
            if (m_writing) begin
                sc_req = 1; addr = sc_addr; dhit = ($urandom_range(2) == 0);
            end else if (!m_done) begin
                pick = $urandom_range(9);
                addr = rand_addr();
                if (pick < 3) begin ll_req = 1; dhit = $urandom_range(1); end
                else if (pick < 5) begin sc_req = 1; sc_addr = addr; end
                else if (pick < 7) begin sw_req = 1; dhit = $urandom_range(1); end
            end
            snoop_inv  = ($urandom_range(4) == 0);
            snoop_addr = rand_addr();
            model_step();
            tick();
            vecs++; if (link_valid !== m_linked) begin errs++; $display("FAIL rnd_link_valid c%0d: got %0h want %0h", c, link_valid, m_linked); end
            vecs++; if (sc_wen !== m_writing) begin errs++; $display("FAIL rnd_sc_wen c%0d: got %0h want %0h", c, sc_wen, m_writing); end
            vecs++; if (sc_done !== m_done) begin errs++; $display("FAIL rnd_sc_done c%0d: got %0h want %0h", c, sc_done, m_done); end
            vecs++; if (sc_result !== m_result) begin errs++; $display("FAIL rnd_sc_result c%0d: got %0h want %0h", c, sc_result, m_result); end
            if (m_linked) begin
                vecs++; if (link_addr !== {m_blk, 3'b000}) begin errs++; $display("FAIL rnd_link_addr c%0d: got %0h want %0h", c, link_addr, {m_blk, 3'b000}); end
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_sc_success();
        test_snoop_break();
        test_nonmatch();
        test_sc_race();
        test_timeout();
        test_reset_mid_sc();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
